// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike rate encoder.
// Holds the FSM state encoding and the Galois LFSR step function.
package spike_enc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GEN     = 2'd1,
    PRESENT = 2'd2
  } enc_state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // Right-shifting Galois step: feedback taps are applied when bit 0 falls out.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16_galois.sv
// 16-bit Galois LFSR register with an advance enable.
// Exposes the low byte of the value it will hold after the next advance.
module lfsr16_galois
  import spike_enc_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  output logic [7:0] next_byte
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_nx;

  assign lfsr_nx   = lfsr_step(lfsr_q);
  assign next_byte = lfsr_nx[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (advance) begin
      lfsr_q <= lfsr_nx;
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Bernoulli spike-vector generator: one channel per GEN cycle, then a
// valid/ready PRESENT phase per timestep for the downstream neuron.
//
// state   | meaning
// IDLE    | config writes accepted, waiting for start
// GEN     | building spk_vec, one channel per cycle, LFSR advancing
// PRESENT | spk_vec offered downstream, held until handshake
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int          N_INPUTS  = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(N_INPUTS)-1:0] cfg_ch,
  input  logic [7:0]                  cfg_intensity,
  input  logic                        start,
  input  logic [7:0]                  window_len,
  input  logic                        abort,
  output logic                        spk_valid,
  input  logic                        spk_ready,
  output logic [N_INPUTS-1:0]         spk_vec,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  step_idx
);

  localparam int CH_W = $clog2(N_INPUTS);

  enc_state_t           state, state_nx;
  logic [CH_W-1:0]      ch_cnt, ch_nx;
  logic [7:0]           len_q, len_nx;
  logic [7:0]           step_nx;
  logic [N_INPUTS-1:0]  vec_nx;
  logic                 valid_nx, done_nx;
  logic                 advance;
  logic [7:0]           rnd_byte;
  logic [7:0]           intensity [N_INPUTS];
  logic                 spike_bit;

  lfsr16_galois #(.SEED(LFSR_SEED)) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (advance),
    .next_byte (rnd_byte)
  );

  assign spike_bit = rnd_byte < intensity[ch_cnt];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) intensity[i] <= 8'd0;
    end else if (cfg_valid && cfg_ready) begin
      intensity[cfg_ch] <= cfg_intensity;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx    = ch_cnt;
    len_nx   = len_q;
    step_nx  = step_idx;
    vec_nx   = spk_vec;
    valid_nx = 1'b0;
    done_nx  = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (!abort && start) begin
          if (window_len != 8'd0) begin
            len_nx   = window_len;
            step_nx  = 8'd0;
            vec_nx   = '0;
            ch_nx    = '0;
            state_nx = GEN;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      GEN: begin
        advance = 1'b1;
        if (abort) begin
          state_nx = IDLE;
        end else begin
          vec_nx[ch_cnt] = spike_bit;
          if (ch_cnt == CH_W'(N_INPUTS - 1)) begin
            state_nx = PRESENT;
            valid_nx = 1'b1;
          end else begin
            ch_nx = ch_cnt + 1'b1;
          end
        end
      end
      PRESENT: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (spk_ready) begin
          if (step_idx == len_q - 8'd1) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            step_nx  = step_idx + 8'd1;
            vec_nx   = '0;
            ch_nx    = '0;
            state_nx = GEN;
          end
        end else begin
          valid_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch_cnt    <= '0;
      len_q     <= 8'd0;
      step_idx  <= 8'd0;
      spk_vec   <= '0;
      spk_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      state     <= state_nx;
      ch_cnt    <= ch_nx;
      len_q     <= len_nx;
      step_idx  <= step_nx;
      spk_vec   <= vec_nx;
      spk_valid <= valid_nx;
      done      <= done_nx;
      busy      <= (state_nx != IDLE);
      cfg_ready <= (state_nx == IDLE);
    end
  end

endmodule
